// File: rtl/retire_stage.sv
// In-order commit stage at the ROB head: retires completed entries, writes the RF,
// hands stores to the dcache over req/ack, turns a mispredict into a squash, stops on halt.
module retire_stage #(
  parameter int XLEN         = 32,
  parameter int ROB_TAG_W    = 4,
  parameter int REG_IDX_W    = 5,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 head_valid,
  input  logic                 head_complete,
  input  logic [ROB_TAG_W-1:0] head_tag,
  input  logic                 head_has_dest,
  input  logic [REG_IDX_W-1:0] head_dest,
  input  logic [XLEN-1:0]      head_value,
  input  logic                 head_is_store,
  input  logic [XLEN-1:0]      head_st_addr,
  input  logic [XLEN-1:0]      head_st_data,
  input  logic [1:0]           head_st_size,
  input  logic                 head_mispred,
  input  logic [XLEN-1:0]      head_target,
  input  logic                 head_halt,
  input  logic                 st_ack,
  output logic                 rob_pop,
  output logic                 rf_we,
  output logic [REG_IDX_W-1:0] rf_idx,
  output logic [XLEN-1:0]      rf_data,
  output logic                 st_req,
  output logic [XLEN-1:0]      st_addr,
  output logic [XLEN-1:0]      st_data,
  output logic [1:0]           st_size,
  output logic                 squash_valid,
  output logic [XLEN-1:0]      squash_pc,
  output logic [ROB_TAG_W-1:0] squash_tag,
  output logic                 halted,
  output logic [31:0]          retire_count
);

  typedef enum logic [1:0] {RUN, ST_WAIT, FLUSH, HALTED} state_t;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
    logic [1:0]      size;
  } st_req_t;

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);

  state_t     state;
  logic [3:0] flush_cnt;
  st_req_t    st_q;
  logic       ready;
  logic       rf_wr_ok;

  assign ready    = head_valid & head_complete & (head_tag != '0);
  assign rf_wr_ok = head_has_dest & (head_dest != '0);

  assign st_addr = st_q.addr;
  assign st_data = st_q.data;
  assign st_size = st_q.size;

  // A store is only popped once the dcache has taken it; everything else pops on ready.
  always_comb begin
    rob_pop = 1'b0;
    case (state)
      RUN:     rob_pop = ready & (head_mispred | head_halt | ~head_is_store);
      ST_WAIT: rob_pop = st_ack;
      default: rob_pop = 1'b0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= RUN;
      flush_cnt    <= '0;
      st_q         <= '0;
      st_req       <= 1'b0;
      rf_we        <= 1'b0;
      rf_idx       <= '0;
      rf_data      <= '0;
      squash_valid <= 1'b0;
      squash_pc    <= '0;
      squash_tag   <= '0;
      halted       <= 1'b0;
      retire_count <= '0;
    end else begin
      rf_we        <= 1'b0;
      squash_valid <= 1'b0;
      if (rob_pop) retire_count <= retire_count + 32'd1;
      case (state)
        RUN: begin
          if (ready) begin
            if (head_mispred) begin
              rf_we        <= rf_wr_ok;
              rf_idx       <= head_dest;
              rf_data      <= head_value;
              squash_valid <= 1'b1;
              squash_pc    <= head_target;
              squash_tag   <= head_tag;
              flush_cnt    <= FLUSH_INIT;
              state        <= FLUSH;
            end else if (head_halt) begin
              halted <= 1'b1;
              state  <= HALTED;
            end else if (head_is_store) begin
              st_req <= 1'b1;
              st_q   <= '{addr: head_st_addr, data: head_st_data, size: head_st_size};
              state  <= ST_WAIT;
            end else begin
              rf_we   <= rf_wr_ok;
              rf_idx  <= head_dest;
              rf_data <= head_value;
            end
          end
        end
        ST_WAIT: begin
          if (st_ack) begin
            st_req <= 1'b0;
            state  <= RUN;
          end
        end
        FLUSH: begin
          // Leaving on the count-of-one cycle gives exactly FLUSH_CYCLES idle cycles.
          flush_cnt <= flush_cnt - 4'd1;
          if (flush_cnt <= 4'd1) state <= RUN;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_retire_stage.sv
// Randomised and directed bench for retire_stage against a cycle-level reference model.
module tb_retire_stage;
  localparam int FC = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        head_valid, head_complete, head_has_dest, head_is_store, head_mispred, head_halt;
  logic [3:0]  head_tag;
  logic [4:0]  head_dest;
  logic [31:0] head_value, head_st_addr, head_st_data, head_target;
  logic [1:0]  head_st_size;
  logic        st_ack;
  logic        rob_pop, rf_we, st_req, squash_valid, halted;
  logic [4:0]  rf_idx;
  logic [31:0] rf_data, st_addr, st_data, squash_pc, retire_count;
  logic [1:0]  st_size;
  logic [3:0]  squash_tag;

  retire_stage #(.XLEN(32), .ROB_TAG_W(4), .REG_IDX_W(5), .FLUSH_CYCLES(FC)) dut (
    .clock(clock), .reset(reset),
    .head_valid(head_valid), .head_complete(head_complete), .head_tag(head_tag),
    .head_has_dest(head_has_dest), .head_dest(head_dest), .head_value(head_value),
    .head_is_store(head_is_store), .head_st_addr(head_st_addr), .head_st_data(head_st_data),
    .head_st_size(head_st_size), .head_mispred(head_mispred), .head_target(head_target),
    .head_halt(head_halt), .st_ack(st_ack), .rob_pop(rob_pop),
    .rf_we(rf_we), .rf_idx(rf_idx), .rf_data(rf_data),
    .st_req(st_req), .st_addr(st_addr), .st_data(st_data), .st_size(st_size),
    .squash_valid(squash_valid), .squash_pc(squash_pc), .squash_tag(squash_tag),
    .halted(halted), .retire_count(retire_count)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;

  typedef struct {
    bit v, c, hd, st, mp, hl;
    logic [3:0] tag;
    logic [4:0] dest;
    logic [31:0] val, sa, sd, tgt;
    logic [1:0] ss;
  } head_t;

  // Reference model: the stage is either halted, flushing for N more cycles,
  // holding one outstanding store, or free to retire the head.
  bit          m_halted, m_st, m_rf_we, m_sq;
  int          m_flush;
  logic [31:0] m_cnt, m_sa, m_sd, m_rf_data, m_sq_pc;
  logic [1:0]  m_ss;
  logic [4:0]  m_rf_idx;
  logic [3:0]  m_sq_tag;

  task automatic model_reset();
    m_halted = 0; m_st = 0; m_rf_we = 0; m_sq = 0; m_flush = 0; m_cnt = 0;
    m_sa = 0; m_sd = 0; m_ss = 0; m_rf_idx = 0; m_rf_data = 0; m_sq_pc = 0; m_sq_tag = 0;
  endtask

  function automatic bit head_ready();
    return head_valid && head_complete && head_tag != 4'd0;
  endfunction

  function automatic bit model_pop();
    if (m_halted || m_flush > 0) return 0;
    if (m_st) return st_ack;
    return head_ready() && (head_mispred || head_halt || !head_is_store);
  endfunction

  task automatic model_edge(input bit p);
    m_rf_we = 0; m_sq = 0;
    if (m_halted) begin
    end else if (m_flush > 0) m_flush--;
    else if (m_st) begin
      if (st_ack) m_st = 0;
    end else if (head_ready()) begin
      if (head_mispred) begin
        m_rf_we = head_has_dest && head_dest != 0; m_rf_idx = head_dest; m_rf_data = head_value;
        m_sq = 1; m_sq_pc = head_target; m_sq_tag = head_tag; m_flush = FC;
      end else if (head_halt) m_halted = 1;
      else if (head_is_store) begin
        m_st = 1; m_sa = head_st_addr; m_sd = head_st_data; m_ss = head_st_size;
      end else begin
        m_rf_we = head_has_dest && head_dest != 0; m_rf_idx = head_dest; m_rf_data = head_value;
      end
    end
    if (p) m_cnt = m_cnt + 1;
  endtask

  task automatic apply(input head_t h);
    head_valid = h.v; head_complete = h.c; head_tag = h.tag; head_has_dest = h.hd;
    head_dest = h.dest; head_value = h.val; head_is_store = h.st; head_st_addr = h.sa;
    head_st_data = h.sd; head_st_size = h.ss; head_mispred = h.mp; head_target = h.tgt;
    head_halt = h.hl;
  endtask

  function automatic head_t alu(input logic [3:0] tag, input logic [4:0] d, input logic [31:0] v);
    head_t h = '{default: 0};
    h.v = 1; h.c = 1; h.tag = tag; h.hd = 1; h.dest = d; h.val = v;
    return h;
  endfunction

  function automatic head_t idle();
    head_t h = '{default: 0};
    return h;
  endfunction

  // One clock: compare the combinational pop mid-cycle, then all registered outputs after the edge.
  task automatic step(input string nm, output bit got_pop);
    bit ep;
    @(negedge clock);
    ep = model_pop();
    got_pop = rob_pop;
    total++;
    if (rob_pop !== ep) begin bad++; $display("FAIL %s rob_pop got=%0b exp=%0b", nm, rob_pop, ep); end
    @(posedge clock);
    model_edge(ep);
    #1;
    total++;
    if (rf_we !== m_rf_we || (m_rf_we && (rf_idx !== m_rf_idx || rf_data !== m_rf_data))) begin
      bad++; $display("FAIL %s rf got=%0b/%0d/%h exp=%0b/%0d/%h", nm, rf_we, rf_idx, rf_data, m_rf_we, m_rf_idx, m_rf_data);
    end
    total++;
    if (st_req !== m_st || (m_st && (st_addr !== m_sa || st_data !== m_sd || st_size !== m_ss))) begin
      bad++; $display("FAIL %s st got=%0b/%h/%h/%0d exp=%0b/%h/%h/%0d", nm, st_req, st_addr, st_data, st_size, m_st, m_sa, m_sd, m_ss);
    end
    total++;
    if (squash_valid !== m_sq || (m_sq && (squash_pc !== m_sq_pc || squash_tag !== m_sq_tag))) begin
      bad++; $display("FAIL %s squash got=%0b/%h/%0d exp=%0b/%h/%0d", nm, squash_valid, squash_pc, squash_tag, m_sq, m_sq_pc, m_sq_tag);
    end
    total++;
    if (halted !== m_halted || retire_count !== m_cnt) begin
      bad++; $display("FAIL %s halt/count got=%0b/%0d exp=%0b/%0d", nm, halted, retire_count, m_halted, m_cnt);
    end
  endtask

  task automatic do_reset();
    apply(idle()); st_ack = 0;
    reset = 1;
    #3;
    model_reset();
    @(negedge clock);
    reset = 0;
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    apply(idle()); st_ack = 0; reset = 1;
    #12;
    model_reset();
    total++;
    if ({rob_pop, rf_we, st_req, squash_valid, halted} !== 5'b0 || retire_count !== 0 ||
        rf_data !== 0 || st_addr !== 0 || squash_pc !== 0) begin
      bad++; $display("FAIL reset outputs pop=%0b we=%0b req=%0b sq=%0b h=%0b cnt=%0d exp all zero",
                      rob_pop, rf_we, st_req, squash_valid, halted, retire_count);
    end
    @(negedge clock); reset = 0;
    @(posedge clock); #1;
  endtask

  task automatic test_alu();
    bit p;
    int pops = 0;
    apply(alu(1, 5, 32'h11)); step("alu0", p); pops += p;
    total++;
    if (rf_we !== 1 || rf_idx !== 5 || rf_data !== 32'h11) begin
      bad++; $display("FAIL alu_x5 got=%0b/%0d/%h exp=1/5/11", rf_we, rf_idx, rf_data);
    end
    apply(alu(2, 6, 32'h22)); step("alu1", p); pops += p;
    apply(alu(3, 0, 32'h33)); step("alu2", p); pops += p;
    total++;
    if (rf_we !== 0 || pops != 3 || retire_count !== 3) begin
      bad++; $display("FAIL alu_x0 got we=%0b pops=%0d cnt=%0d exp 0/3/3", rf_we, pops, retire_count);
    end
    apply(idle()); step("alu_idle", p);
  endtask

  task automatic test_store();
    head_t h = '{default: 0};
    bit p;
    int reqs = 0, pops = 0;
    h.v = 1; h.c = 1; h.tag = 2; h.st = 1; h.sa = 32'h1000; h.sd = 32'hDEADBEEF; h.ss = 2;
    apply(h); step("st_issue", p); pops += p;
    for (int i = 0; i < 4; i++) begin
      reqs += (st_req === 1'b1 && st_addr === 32'h1000 && st_data === 32'hDEADBEEF && st_size === 2'd2);
      st_ack = (i == 3);
      step("st_wait", p); pops += p;
    end
    st_ack = 0; apply(idle()); step("st_done", p); pops += p;
    total++;
    if (reqs != 4 || pops != 1 || st_req !== 0 || retire_count !== 4) begin
      bad++; $display("FAIL store got reqs=%0d pops=%0d req=%0b cnt=%0d exp 4/1/0/4", reqs, pops, st_req, retire_count);
    end
  endtask

  task automatic test_mispred();
    head_t h = alu(5, 1, 32'h104);
    bit p;
    int pops = 0;
    h.mp = 1; h.tgt = 32'h200;
    apply(h); step("mp", p);
    total++;
    if (!p || squash_valid !== 1 || squash_pc !== 32'h200 || squash_tag !== 5 || rf_we !== 1 ||
        rf_idx !== 1 || rf_data !== 32'h104) begin
      bad++; $display("FAIL mispred got pop=%0b sq=%0b pc=%h tag=%0d rf=%0d/%h", p, squash_valid, squash_pc, squash_tag, rf_idx, rf_data);
    end
    apply(alu(6, 7, 32'h77));
    for (int i = 0; i < FC; i++) begin step("flush", p); pops += p; end
    step("post_flush", p);
    total++;
    if (pops != 0 || !p) begin
      bad++; $display("FAIL flush_len got flush_pops=%0d post_pop=%0b exp 0/1", pops, p);
    end
    apply(idle()); step("mp_idle", p);
  endtask

  task automatic test_halt();
    head_t h = '{default: 0};
    bit p;
    int pops = 0;
    h.v = 1; h.c = 1; h.tag = 7; h.hl = 1;
    apply(h); step("halt", p);
    apply(alu(8, 3, 32'h99));
    for (int i = 0; i < 20; i++) begin step("halted", p); pops += p; end
    total++;
    if (halted !== 1 || pops != 0 || rf_we !== 0) begin
      bad++; $display("FAIL halt got halted=%0b pops=%0d we=%0b exp 1/0/0", halted, pops, rf_we);
    end
    do_reset();
  endtask

  task automatic test_reset_mid_store();
    head_t h = '{default: 0};
    bit p;
    apply(alu(1, 4, 32'h5)); step("pre", p);
    h.v = 1; h.c = 1; h.tag = 3; h.st = 1; h.sa = 32'h40; h.sd = 32'h1234; h.ss = 1;
    apply(h); step("st_issue2", p);
    step("st_hold", p);
    #2 reset = 1;
    #1;
    total++;
    if (st_req !== 0 || retire_count !== 0) begin
      bad++; $display("FAIL async_reset got req=%0b cnt=%0d exp 0/0", st_req, retire_count);
    end
    model_reset();
    apply(idle());
    @(negedge clock); reset = 0;
    @(posedge clock); #1;
    apply(alu(2, 9, 32'hAB)); step("after_rst", p);
    total++;
    if (!p || retire_count !== 1 || st_req !== 0) begin
      bad++; $display("FAIL run_after_reset got pop=%0b cnt=%0d req=%0b exp 1/1/0", p, retire_count, st_req);
    end
    apply(idle()); step("rst_idle", p);
  endtask

  task automatic test_stall();
    head_t h = alu(4, 10, 32'h1010);
    bit p;
    int pops = 0;
    h.c = 0; apply(h);
    for (int i = 0; i < 3; i++) begin step("stall", p); pops += p; end
    h.c = 1; apply(h); step("unstall", p);
    total++;
    if (pops != 0 || !p) begin
      bad++; $display("FAIL stall got stalled_pops=%0d last_pop=%0b exp 0/1", pops, p);
    end
    apply(idle()); step("stall_idle", p);
  endtask

  task automatic test_random();
    head_t h = idle();
    bit p = 1;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if (p || !h.v || $urandom_range(0, 3) == 0) begin
        h = '{default: 0};
        h.v = ($urandom_range(0, 9) != 0);
        h.tag = 4'($urandom_range(0, 15));
        h.hd = $urandom_range(0, 1);
        h.dest = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
        h.val = $urandom; h.sa = $urandom; h.sd = $urandom; h.tgt = $urandom;
        h.ss = 2'($urandom_range(0, 2));
        h.st = ($urandom_range(0, 3) == 0);
        h.mp = ($urandom_range(0, 9) == 0);
      end
      h.c = ($urandom_range(0, 9) < 7);
      apply(h);
      st_ack = ($urandom_range(0, 9) < 3);
      step("rand", p);
    end
    st_ack = 0; apply(idle());
  endtask

  initial begin
    test_reset();
    test_alu();
    test_store();
    test_mispred();
    test_halt();
    test_reset_mid_store();
    test_stall();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
